matrix_mult_engine: RTL and testbench

- Compute engine for the matrix multiplier: C = A x B over 10x10 unsigned matrices.
- Sits downstream of two matrix_10x10 storage instances (A, B), driving their read ports.
- Writes each result element into a third, wider matrix_10x10 instance (C) through its write port.
- Sequenced by an FSM with row/column/inner-index counters and a one-stage read pipeline.

---
 rtl/matrix_pkg.sv | 13 +
 rtl/matrix_mult_engine_if.sv | 36 +++
 rtl/matrix_mult_engine_mac_unit.sv | 28 ++
 rtl/matrix_mult_engine.sv | 121 ++++++++++++
 tb/tb_matrix_mult_engine.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared constants and types for the matrix multiply engine
package matrix_pkg;
    localparam int N          = 10;
    localparam int ADDR_WIDTH = 4;
    localparam int DATA_WIDTH = 8;
    localparam int ACC_WIDTH  = 20;

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, WRITE, FIN} state_t;

    typedef logic [ADDR_WIDTH-1:0] idx_t;

    localparam idx_t LAST_IDX = idx_t'(N - 1);
endpackage

// File: rtl/matrix_mult_engine_if.sv
// rtl/matrix_mult_engine_if.sv - control and A/B/C matrix port bundle for the engine
interface matrix_mult_engine_if;
    import matrix_pkg::*;

    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  a_en_ReadMat;
    idx_t                  a_rowAddr;
    idx_t                  a_colAddr;
    logic [DATA_WIDTH-1:0] a_readData;
    logic                  b_en_ReadMat;
    idx_t                  b_rowAddr;
    idx_t                  b_colAddr;
    logic [DATA_WIDTH-1:0] b_readData;
    logic                  c_en_WriteMat;
    idx_t                  c_rowAddr;
    idx_t                  c_colAddr;
    logic [ACC_WIDTH-1:0]  c_writeData;

    modport master (
        input  start, a_readData, b_readData,
        output busy, done,
        output a_en_ReadMat, a_rowAddr, a_colAddr,
        output b_en_ReadMat, b_rowAddr, b_colAddr,
        output c_en_WriteMat, c_rowAddr, c_colAddr, c_writeData
    );

    modport slave (
        output start, a_readData, b_readData,
        input  busy, done,
        input  a_en_ReadMat, a_rowAddr, a_colAddr,
        input  b_en_ReadMat, b_rowAddr, b_colAddr,
        input  c_en_WriteMat, c_rowAddr, c_colAddr, c_writeData
    );
endinterface

// File: rtl/matrix_mult_engine_mac_unit.sv
// rtl/matrix_mult_engine_mac_unit.sv - registered unsigned multiply-accumulate with clear
module mac_unit #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  valid,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [ACC_WIDTH-1:0]  acc
);
    logic [2*DATA_WIDTH-1:0] prod;

    assign prod = a * b;

    // Clear wins over valid; the sum wraps modulo 2^ACC_WIDTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (valid) begin
            acc <= acc + {{(ACC_WIDTH-2*DATA_WIDTH){1'b0}}, prod};
        end
    end
endmodule

// File: rtl/matrix_mult_engine.sv
// rtl/matrix_mult_engine.sv - sequences A/B reads, MAC accumulation and C writes for C = A x B
module matrix_mult_engine
    import matrix_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    matrix_mult_engine_if.master bus
);
    state_t               state, state_nxt;
    idx_t                 i, j, k;
    idx_t                 rd_i_q, rd_k_q, rd_j_q, wr_i_q, wr_j_q;
    logic                 pipe_valid;
    logic                 rd_en, wr_en, acc_clear;
    logic                 last_k, last_elem;
    logic [ACC_WIDTH-1:0] acc;

    assign last_k    = (k == LAST_IDX);
    assign last_elem = (i == LAST_IDX) && (j == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last_k) state_nxt = DRAIN;
            DRAIN:   state_nxt = WRITE;
            WRITE:   state_nxt = last_elem ? FIN : RUN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Addresses fall back to the last presented value whenever their enable is low.
    always_comb begin
        rd_en             = (state == RUN);
        wr_en             = (state == WRITE);
        acc_clear         = wr_en || ((state == IDLE) && bus.start);
        bus.busy          = (state != IDLE);
        bus.done          = (state == FIN);
        bus.a_en_ReadMat  = rd_en;
        bus.b_en_ReadMat  = rd_en;
        bus.c_en_WriteMat = wr_en;
        bus.a_rowAddr     = rd_en ? i : rd_i_q;
        bus.a_colAddr     = rd_en ? k : rd_k_q;
        bus.b_rowAddr     = rd_en ? k : rd_k_q;
        bus.b_colAddr     = rd_en ? j : rd_j_q;
        bus.c_rowAddr     = wr_en ? i : wr_i_q;
        bus.c_colAddr     = wr_en ? j : wr_j_q;
        bus.c_writeData   = acc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i          <= '0;
            j          <= '0;
            k          <= '0;
            rd_i_q     <= '0;
            rd_k_q     <= '0;
            rd_j_q     <= '0;
            wr_i_q     <= '0;
            wr_j_q     <= '0;
            pipe_valid <= 1'b0;
        end else begin
            // Read data lands one cycle after the address, so valid trails RUN by one.
            pipe_valid <= rd_en;
            if (rd_en) begin
                rd_i_q <= i;
                rd_k_q <= k;
                rd_j_q <= j;
            end
            if (wr_en) begin
                wr_i_q <= i;
                wr_j_q <= j;
            end
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        i <= '0;
                        j <= '0;
                        k <= '0;
                    end
                end
                RUN: begin
                    if (!last_k) k <= k + idx_t'(1);
                end
                WRITE: begin
                    k <= '0;
                    if (!last_elem) begin
                        if (j == LAST_IDX) begin
                            j <= '0;
                            i <= i + idx_t'(1);
                        end else begin
                            j <= j + idx_t'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    mac_unit #(
        .DATA_WIDTH(DATA_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_mac (
        .clk  (clk),
        .rst  (rst),
        .clear(acc_clear),
        .valid(pipe_valid),
        .a    (bus.a_readData),
        .b    (bus.b_readData),
        .acc  (acc)
    );
endmodule

// File: tb/tb_matrix_mult_engine.sv
// tb/tb_matrix_mult_engine.sv - scoreboard bench for matrix_mult_engine with A/B/C memory models
module tb_matrix_mult_engine;
    logic clk = 1'b0;
    logic rst;
    logic c_clr;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    typedef struct {
        int cyc;
        bit is_done;
        int row;
        int col;
        int data;
    } exp_t;

    exp_t sb[$];

    logic [7:0]  a_m [0:9][0:9];
    logic [7:0]  b_m [0:9][0:9];
    logic [19:0] c_m [0:9][0:9];

    localparam logic [19:0] SENTINEL = 20'hFFFFF;

    matrix_mult_engine_if bus();

    matrix_mult_engine dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Registered-read A/B memories and the C write port.
    always @(posedge clk) begin
        if (bus.a_en_ReadMat) bus.a_readData <= a_m[bus.a_rowAddr][bus.a_colAddr];
        if (bus.b_en_ReadMat) bus.b_readData <= b_m[bus.b_rowAddr][bus.b_colAddr];
        if (c_clr) begin
            for (int r = 0; r < 10; r++)
                for (int c = 0; c < 10; c++)
                    c_m[r][c] <= SENTINEL;
        end else if (bus.c_en_WriteMat) begin
            c_m[bus.c_rowAddr][bus.c_colAddr] <= bus.c_writeData;
        end
    end

    task automatic tally(input bit ok, input string msg);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s", msg);
        end
    endtask

    // Monitor: pop the scoreboard whenever the engine writes C or pulses done.
    always @(negedge clk) begin
        exp_t e;
        if (bus.c_en_WriteMat) begin
            if (sb.size() == 0) begin
                tally(1'b0, $sformatf("unexpected_write cyc=%0d at (%0d,%0d) data=%0d, required no write",
                                      cyc, bus.c_rowAddr, bus.c_colAddr, bus.c_writeData));
            end else begin
                e = sb.pop_front();
                tally(!e.is_done && e.cyc == cyc && e.row == int'(bus.c_rowAddr) &&
                      e.col == int'(bus.c_colAddr) && e.data == int'(bus.c_writeData) &&
                      !bus.a_en_ReadMat && !bus.b_en_ReadMat,
                      $sformatf("c_write got cyc=%0d (%0d,%0d)=%0d a_en=%0b b_en=%0b, required done=%0b cyc=%0d (%0d,%0d)=%0d enables 0",
                                cyc, bus.c_rowAddr, bus.c_colAddr, bus.c_writeData,
                                bus.a_en_ReadMat, bus.b_en_ReadMat,
                                e.is_done, e.cyc, e.row, e.col, e.data));
            end
        end
        if (bus.done) begin
            if (sb.size() == 0) begin
                tally(1'b0, $sformatf("unexpected_done cyc=%0d, required no done", cyc));
            end else begin
                e = sb.pop_front();
                tally(e.is_done && e.cyc == cyc && bus.busy,
                      $sformatf("done got cyc=%0d busy=%0b, required done entry=%0b cyc=%0d busy=1",
                                cyc, bus.busy, e.is_done, e.cyc));
            end
        end
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic push_write(input int s, input int m, input int data);
        exp_t e;
        e.cyc = s + 12*m + 12;
        e.is_done = 1'b0;
        e.row = m / 10;
        e.col = m % 10;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic push_done(input int s);
        exp_t e;
        e.cyc = s + 1201;
        e.is_done = 1'b1;
        e.row = 0;
        e.col = 0;
        e.data = 0;
        sb.push_back(e);
    endtask

    task automatic check_outputs_zero(input string tag);
        tally({bus.busy, bus.done, bus.a_en_ReadMat, bus.b_en_ReadMat, bus.c_en_WriteMat} == 5'b0,
              $sformatf("%s_ctrl got busy,done,a_en,b_en,c_en=%05b, required 00000", tag,
                        {bus.busy, bus.done, bus.a_en_ReadMat, bus.b_en_ReadMat, bus.c_en_WriteMat}));
        tally({bus.a_rowAddr, bus.a_colAddr, bus.b_rowAddr, bus.b_colAddr, bus.c_rowAddr, bus.c_colAddr} == 24'h0,
              $sformatf("%s_addr got %06h, required 000000", tag,
                        {bus.a_rowAddr, bus.a_colAddr, bus.b_rowAddr, bus.b_colAddr, bus.c_rowAddr, bus.c_colAddr}));
        tally(bus.c_writeData == 20'h0,
              $sformatf("%s_data got %0d, required 0", tag, bus.c_writeData));
    endtask

    task automatic load_identity_random();
        for (int r = 0; r < 10; r++)
            for (int c = 0; c < 10; c++) begin
                a_m[r][c] = (r == c) ? 8'd1 : 8'd0;
                b_m[r][c] = 8'($urandom_range(255));
            end
    endtask

    task automatic check_sb_empty(input string tag);
        tally(sb.size() == 0, $sformatf("%s pending=%0d, required 0", tag, sb.size()));
    endtask

    initial begin
        int s;
        int bad;
        rst = 1'b1;
        c_clr = 1'b0;
        bus.start = 1'b0;
        bus.a_readData = '0;
        bus.b_readData = '0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Identity x random: C must equal B; also exact start/done/idle timing.
        load_identity_random();
        s = cyc;
        for (int m = 0; m < 100; m++) push_write(s, m, int'(b_m[m/10][m%10]));
        push_done(s);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_cyc(s + 1202);
        tally({bus.busy, bus.done} == 2'b00,
              $sformatf("idle_after_fin got busy,done=%02b, required 00", {bus.busy, bus.done}));
        check_sb_empty("run1_complete");

        // All-ones x row-index, start held high so a second (all-255) run follows FIN.
        for (int r = 0; r < 10; r++)
            for (int c = 0; c < 10; c++) begin
                a_m[r][c] = 8'd1;
                b_m[r][c] = 8'(r);
            end
        s = cyc;
        for (int m = 0; m < 100; m++) push_write(s, m, 45);
        push_done(s);
        for (int m = 0; m < 100; m++) push_write(s + 1202, m, 650250);
        push_done(s + 1202);
        bus.start = 1'b1;
        wait_cyc(s + 1201);
        for (int r = 0; r < 10; r++)
            for (int c = 0; c < 10; c++) begin
                a_m[r][c] = 8'd255;
                b_m[r][c] = 8'd255;
            end
        wait_cyc(s + 1202);
        tally(!bus.busy, $sformatf("held_start_gap got busy=%0b, required 0", bus.busy));
        s = s + 1202;
        wait_cyc(s + 1);
        bus.start = 1'b0;
        wait_cyc(s + 5);
        bus.start = 1'b1;
        wait_cyc(s + 6);
        bus.start = 1'b0;
        wait_cyc(s + 600);
        bus.start = 1'b1;
        wait_cyc(s + 601);
        bus.start = 1'b0;
        wait_cyc(s + 1202);
        tally({bus.busy, bus.done} == 2'b00,
              $sformatf("idle_after_run3 got busy,done=%02b, required 00", {bus.busy, bus.done}));
        check_sb_empty("run3_complete");

        // Reset at cycle 400 of a run: elements 0..32 written, then abort.
        c_clr = 1'b1;
        @(negedge clk);
        c_clr = 1'b0;
        load_identity_random();
        s = cyc;
        for (int m = 0; m <= 32; m++) push_write(s, m, int'(b_m[m/10][m%10]));
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_cyc(s + 400);
        rst = 1'b1;
        #1;
        check_outputs_zero("abort");
        wait_cyc(s + 410);
        rst = 1'b0;
        check_sb_empty("abort_writes");
        bad = 0;
        for (int m = 0; m < 100; m++)
            if (c_m[m/10][m%10] != ((m <= 32) ? 20'(b_m[m/10][m%10]) : SENTINEL)) bad++;
        tally(bad == 0, $sformatf("abort_retained got %0d wrong C cells, required 0", bad));

        wait_cyc(s + 415);
        s = cyc;
        for (int m = 0; m < 100; m++) push_write(s, m, int'(b_m[m/10][m%10]));
        push_done(s);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_cyc(s + 1203);
        check_sb_empty("rerun_complete");
        bad = 0;
        for (int m = 0; m < 100; m++)
            if (c_m[m/10][m%10] != 20'(b_m[m/10][m%10])) bad++;
        tally(bad == 0, $sformatf("rerun_c_contents got %0d wrong C cells, required 0", bad));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
